square_collision_detect: RTL
============================

Name: square_collision_detect

Overview:
- Read-side counterpart to the draw stages in the VGA pipeline. It samples the rgb stream inside a square window at (xpos_square, ypos_square) and counts pixels equal to TARGET_COLOR.
- Once per frame it reports the count and a hit flag for game/control logic.
- Sits in-line in the vga_if chain and forwards the stream with one register stage, so it can be placed anywhere between draw stages.

Parameters:
- WIDTH, 8, window width offset; window covers hcount xpos..xpos+WIDTH inclusive.
- HEIGHT, 8, window height offset; window covers vcount ypos..ypos+HEIGHT inclusive.
- TARGET_COLOR, 12'h0_f_0, rgb value counted as colliding.
- HIT_THRESHOLD, 1, minimum matching pixels per frame for hit=1 (1..65535).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- xpos_square  in  12  window left edge; sampled at frame start.
- ypos_square  in  12  window top edge; sampled at frame start.
- vga_in  vga_if.in  -  incoming stream (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb).
- vga_out  vga_if.out  -  same stream delayed by one clk.
- hit  out  1  hit_count >= HIT_THRESHOLD for the last completed frame.
- hit_count  out  16  matching-pixel count of the last completed frame.
- frame_done  out  1  one-cycle pulse when hit and hit_count update.

Behaviour:
- Reset: all vga_out fields, hit, hit_count and frame_done are 0. Internal count is 0, prev_vblnk is 0, latched positions are 0, state is WAIT_FRAME.
- Pass-through: every vga_out field equals the corresponding vga_in field from the previous cycle. rgb is never modified.
- Frame edges come from a registered prev_vblnk:
  - frame start = prev_vblnk=1 and vga_in.vblnk=0.
  - frame end = prev_vblnk=0 and vga_in.vblnk=1.
- WAIT_FRAME:
  - Count is held at 0.
  - On frame start: latch xpos_square/ypos_square, clear count, go to SCAN.
  - The current pixel is evaluated in SCAN logic on the same cycle, using the newly latched positions.
- SCAN:
  - A pixel qualifies when all of the following hold:
    - vga_in.hblnk=0 and vga_in.vblnk=0;
    - hcount >= x_lat and hcount <= x_lat+WIDTH;
    - vcount >= y_lat and vcount <= y_lat+HEIGHT;
    - vga_in.rgb == TARGET_COLOR.
  - A qualifying pixel increments count by 1. Count saturates at 16'hFFFF.
  - On frame end: go to REPORT.
- REPORT (exactly one cycle):
  - hit_count <= count; hit <= (count >= HIT_THRESHOLD); frame_done <= 1.
  - Then go to WAIT_FRAME.
  - frame_done is 0 in every other cycle.
- hit and hit_count hold their values between reports.
- Arithmetic: window bounds are computed 13 bits wide (x_lat+WIDTH, y_lat+HEIGHT), so a window past 4095 clips instead of wrapping.
- xpos/ypos changes mid-frame have no effect until the next frame start (no tearing).
- Reset mid-frame: outputs go to reset values and the partial frame is discarded. The first report comes at the end of the first complete frame after a vblnk falling edge.
- When no frame start occurs (stream stalled in vblnk), the block stays in WAIT_FRAME and outputs hold.

Test Plan:
- Reset with 800x600 timing running: all outputs 0; vga_out equals vga_in delayed 1 cycle on every field throughout.
- xpos=100, ypos=50, upstream fills the whole screen with 12'h0_f_0, THRESHOLD=1: frame_done pulses once per frame, 1 cycle wide, with hit_count=81 and hit=1.
- Same window, stream all 12'h0_0_0: hit_count=0, hit=0. Then only pixel (108,58) is green: hit_count=1, hit=1. Then only pixel (109,58) is green: hit_count=0.
- THRESHOLD=82 with the full-green window: hit_count=81, hit=0. THRESHOLD=81: hit=1.
- xpos changes 100→300 while vcount=300: the current frame still reports the window at 100. The next frame uses 300.
- rst asserted for 2 cycles at vcount=200: no frame_done at the end of that frame. The next full frame reports the correct count. Separately, xpos=4090 with WIDTH=8 gives no wrap and no matches at hcount 0..2.

Source files
------------

// File: rtl/square_collision_detect_if.sv
// VGA stream bundle shared by the draw and read stages of the video pipeline.
// One instance per hop; "in" is the consumer view, "out" the producer view.
interface vga_if;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (
        input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );

    modport out (
        output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );
endinterface

// File: rtl/square_collision_detect.sv
// Counts TARGET_COLOR pixels inside a square window once per frame and
// forwards the VGA stream unchanged with a single register stage.
module square_collision_detect #(
    parameter int          WIDTH         = 8,
    parameter int          HEIGHT        = 8,
    parameter logic [11:0] TARGET_COLOR  = 12'h0_f_0,
    parameter int          HIT_THRESHOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos_square,
    input  logic [11:0] ypos_square,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    output logic        hit,
    output logic [15:0] hit_count,
    output logic        frame_done
);

    localparam logic [1:0]  WAIT_FRAME = 2'd0;
    localparam logic [1:0]  SCAN       = 2'd1;
    localparam logic [1:0]  REPORT     = 2'd2;
    localparam logic [12:0] W13        = 13'(WIDTH);
    localparam logic [12:0] H13        = 13'(HEIGHT);
    localparam logic [15:0] THR        = 16'(HIT_THRESHOLD);

    logic [39:0] stream_q, stream_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [11:0] x_lat_q, x_lat_d;
    logic [11:0] y_lat_q, y_lat_d;
    logic        prev_vblnk_q, prev_vblnk_d;
    logic        hit_q, hit_d;
    logic [15:0] hit_count_q, hit_count_d;
    logic        frame_done_q, frame_done_d;

    logic        frame_start, frame_end;
    logic        scan_now, pix_ok;
    logic [11:0] x_win, y_win;
    logic [12:0] x_hi, y_hi;
    logic [15:0] count_base;

    always_comb begin
        stream_d = {vga_in.vcount, vga_in.vsync, vga_in.vblnk,
                    vga_in.hcount, vga_in.hsync, vga_in.hblnk,
                    vga_in.rgb};
    end

    assign vga_out.vcount = stream_q[39:28];
    assign vga_out.vsync  = stream_q[27];
    assign vga_out.vblnk  = stream_q[26];
    assign vga_out.hcount = stream_q[25:14];
    assign vga_out.hsync  = stream_q[13];
    assign vga_out.hblnk  = stream_q[12];
    assign vga_out.rgb    = stream_q[11:0];

    assign frame_start = prev_vblnk_q & ~vga_in.vblnk;
    assign frame_end   = ~prev_vblnk_q & vga_in.vblnk;
    assign scan_now    = (state_q == SCAN) ||
                         (state_q == WAIT_FRAME && frame_start);

    // The start-of-frame pixel is judged against the freshly latched window.
    always_comb begin
        x_win = x_lat_q;
        y_win = y_lat_q;
        if (state_q == WAIT_FRAME && frame_start) begin
            x_win = xpos_square;
            y_win = ypos_square;
        end
        // 13-bit bounds let a window past 4095 clip instead of wrapping.
        x_hi   = {1'b0, x_win} + W13;
        y_hi   = {1'b0, y_win} + H13;
        pix_ok = !vga_in.hblnk && !vga_in.vblnk &&
                 (vga_in.hcount >= x_win) &&
                 ({1'b0, vga_in.hcount} <= x_hi) &&
                 (vga_in.vcount >= y_win) &&
                 ({1'b0, vga_in.vcount} <= y_hi) &&
                 (vga_in.rgb == TARGET_COLOR);
        count_base = (state_q == SCAN) ? count_q : 16'd0;
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        prev_vblnk_d = vga_in.vblnk;
        hit_d        = hit_q;
        hit_count_d  = hit_count_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            WAIT_FRAME: begin
                count_d = 16'd0;
                if (frame_start) begin
                    x_lat_d = xpos_square;
                    y_lat_d = ypos_square;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (frame_end) state_d = REPORT;
            end
            REPORT: begin
                hit_count_d  = count_q;
                hit_d        = (count_q >= THR);
                frame_done_d = 1'b1;
                state_d      = WAIT_FRAME;
            end
            default: state_d = WAIT_FRAME;
        endcase
        if (scan_now && pix_ok && count_base != 16'hFFFF)
            count_d = count_base + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stream_q     <= '0;
            state_q      <= WAIT_FRAME;
            count_q      <= '0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            prev_vblnk_q <= 1'b0;
            hit_q        <= 1'b0;
            hit_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            stream_q     <= stream_d;
            state_q      <= state_d;
            count_q      <= count_d;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            prev_vblnk_q <= prev_vblnk_d;
            hit_q        <= hit_d;
            hit_count_q  <= hit_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign hit        = hit_q;
    assign hit_count  = hit_count_q;
    assign frame_done = frame_done_q;

endmodule
